dir_input_ctrl: RTL and testbench
=================================

DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 500000: consecutive sys_clk cycles a synchronized button level must differ from its debounced level before the debounced level changes.
REQ-002 SHALL have port sys_clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports btn_up, btn_right, btn_down, btn_left, input, 1 each: raw asynchronous push-buttons, active-high.
REQ-005 SHALL have port update_clk, input, 1: game-step strobe from the game logic, a level signal in the sys_clk domain.
REQ-006 SHALL have port dir, output, [0:1]: current movement direction for the game logic; 00 up, 01 right, 10 down, 11 left.
REQ-007 SHALL have port q_count, output, [1:0]: number of pending turns in the queue, 0..2.
REQ-008 SHALL have port turn_drop, output, 1: one-cycle pulse when a press event is rejected or discarded.

Function
REQ-009 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-010 SHALL debounce each button with its own counter.
- Counter clears whenever the synchronized level equals the debounced level.
- Counter otherwise increments.
- Debounced level toggles, and the counter clears, in the cycle the counter reaches DB_CYCLES-1 with a mismatch still present.
REQ-011 SHALL raise a one-cycle press event on each 0->1 transition of a debounced level.
REQ-012 SHALL, when several press events occur in one cycle, keep only the highest priority (up > right > down > left) and drop the rest without pulsing turn_drop for them.
REQ-013 SHALL take as reference direction the queue tail entry if q_count>0, otherwise dir, both sampled from pre-edge state.
REQ-014 SHALL reject a candidate equal to the reference or equal to the reference XOR 2'b10 (180-degree reversal); rejection pulses turn_drop in the next cycle.
REQ-015 SHALL hold accepted candidates in a 2-entry FIFO.
- Push when q_count<2, or when q_count==2 and a pop occurs in the same cycle.
- Otherwise discard the candidate and pulse turn_drop.
REQ-016 SHALL detect a step tick when update_clk==1 and its registered previous value==0.
REQ-017 SHALL, on a step tick with q_count>0, load dir from the FIFO head and pop.
- The new dir and q_count are visible one cycle after the tick cycle.
- A tick with an empty FIFO leaves dir unchanged.
REQ-018 SHALL pop at most one entry per tick; a second queued turn waits for the next tick.
REQ-019 SHALL, on push and pop in the same cycle, leave q_count unchanged and preserve FIFO order (pushed entry becomes tail).
REQ-020 SHALL keep dir stable between ticks regardless of button activity.

Reset
REQ-021 SHALL, when sys_rst==1 at a clock edge, set dir=01 (right), q_count=0, turn_drop=0, empty the FIFO, clear all debounce counters, debounced levels, synchronizer flops and the update_clk history register to 0.
REQ-022 SHALL give reset priority over any simultaneous press event or tick, including mid-debounce and with a non-empty FIFO.
REQ-023 SHALL not let a button held through reset generate a press until after its debounce interval following reset release.

Verification (DB_CYCLES=4)
REQ-024 Debounce: glitch btn_up high for 3 cycles, then low -> no press, q_count stays 0. Hold btn_up for 10 cycles -> one push, q_count=1.
REQ-025 Turn apply: from reset (dir=01), press down, then one update_clk rising edge -> dir=10 one cycle after the tick, q_count=0.
REQ-026 Reversal reject: dir=01, queue empty, press left -> q_count stays 0, one turn_drop pulse. Press right -> same rejection.
REQ-027 Two-turn queue: dir=01, press up then left before any tick -> q_count=2.
- First tick -> dir=00, q_count=1.
- Second tick -> dir=11, q_count=0.
- A third press, down, while q_count=2 -> turn_drop pulse; down is discarded, not queued.
REQ-028 Simultaneous events: btn_up and btn_down debounce in the same cycle with dir=01 -> only up queued, no turn_drop. Push coinciding with a tick at q_count=2 -> q_count stays 2, order preserved.
REQ-029 Reset mid-operation: q_count=2 and a debounce in progress; assert sys_rst one cycle -> dir=01, q_count=0; no press for the held button until 4 cycles after release.

Source files
------------

// File: rtl/dir_input_ctrl.sv
// Direction input controller: synchronizes and debounces four buttons, turns
// press events into queued turns and applies one queued turn per game step.
module dir_input_ctrl #(
  parameter int DB_CYCLES = 500000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       update_clk,
  output logic [0:1] dir,
  output logic [1:0] q_count,
  output logic       turn_drop
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Bit index equals the direction code: 0 up, 1 right, 2 down, 3 left.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_left, btn_down, btn_right, btn_up};

  logic [3:0]    sync1, sync2, db_level;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    db_flip, press;

  logic [1:0] dir_q;
  logic [1:0] fifo_q [2];
  logic       upd_prev;

  logic       cand_valid, reject, tick, pop, push, drop;
  logic [1:0] cand, ref_dir;

  always_comb begin
    db_flip = '0;
    for (int i = 0; i < 4; i++) begin
      db_flip[i] = (sync2[i] != db_level[i]) && (db_cnt[i] == CNT_LAST);
    end
    press = db_flip & ~db_level;
  end

  always_comb begin
    cand_valid = |press;
    if (press[0])      cand = 2'd0;
    else if (press[1]) cand = 2'd1;
    else if (press[2]) cand = 2'd2;
    else               cand = 2'd3;

    // Turns are judged against the last direction the snake will have taken.
    if (q_count == 2'd2)      ref_dir = fifo_q[1];
    else if (q_count == 2'd1) ref_dir = fifo_q[0];
    else                      ref_dir = dir_q;

    reject = (cand == ref_dir) || (cand == (ref_dir ^ 2'b10));
    tick   = update_clk && !upd_prev;
    pop    = tick && (q_count != 2'd0);
    push   = cand_valid && !reject && ((q_count != 2'd2) || pop);
    drop   = cand_valid && !push;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_flip[i]) begin
          db_level[i] <= ~db_level[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dir_q     <= 2'b01;
      q_count   <= 2'd0;
      fifo_q[0] <= 2'd0;
      fifo_q[1] <= 2'd0;
      turn_drop <= 1'b0;
      upd_prev  <= 1'b0;
    end else begin
      upd_prev  <= update_clk;
      turn_drop <= drop;
      if (pop) dir_q <= fifo_q[0];
      case ({push, pop})
        2'b10: begin
          if (q_count == 2'd0) fifo_q[0] <= cand;
          else                 fifo_q[1] <= cand;
          q_count <= q_count + 2'd1;
        end
        2'b01: begin
          fifo_q[0] <= fifo_q[1];
          q_count   <= q_count - 2'd1;
        end
        2'b11: begin
          // Head leaves, the new turn becomes the tail; depth is unchanged.
          if (q_count == 2'd1) begin
            fifo_q[0] <= cand;
          end else begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= cand;
          end
        end
        default: ;
      endcase
    end
  end

  assign dir = dir_q;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Bench for dir_input_ctrl with DB_CYCLES=4; exp_q holds the turns expected
// to be pending, popped and compared against dir on each step tick.
module tb_dir_input_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       update_clk = 1'b0;
  logic [0:1] dir;
  logic [1:0] q_count;
  logic       turn_drop;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];
  logic [1:0] cur_dir = 2'b01;

  dir_input_ctrl #(.DB_CYCLES(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .update_clk(update_clk), .dir(dir), .q_count(q_count), .turn_drop(turn_drop)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_btns(input logic [3:0] m);
    btn_up = m[0]; btn_right = m[1]; btn_down = m[2]; btn_left = m[3];
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_q.delete();
    cur_dir = 2'b01;
    check("rst_dir", 32'(dir), 32'(2'b01));
    check("rst_qcount", 32'(q_count), 0);
    check("rst_drop", 32'(turn_drop), 0);
  endtask

  // Reference model for one press event; returns expected drop count.
  function automatic int model_press(input logic [3:0] m);
    logic [1:0] c, r;
    c = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    r = (exp_q.size() != 0) ? exp_q[$] : cur_dir;
    if (c == r || c == (r ^ 2'b10)) return 1;
    if (exp_q.size() == 2) return 1;
    exp_q.push_back(c);
    return 0;
  endfunction

  // Hold buttons long enough to debounce, release, count turn_drop pulses.
  task automatic press(input string tag, input logic [3:0] m, input int hold);
    int drops, exp_drops;
    drops = 0;
    exp_drops = (hold >= 6) ? model_press(m) : 0;
    set_btns(m);
    repeat (hold) begin
      @(negedge sys_clk);
      drops += int'(turn_drop);
    end
    set_btns(4'b0);
    repeat (8) begin
      @(negedge sys_clk);
      drops += int'(turn_drop);
    end
    check({tag, "_drops"}, 32'(drops), 32'(exp_drops));
    check({tag, "_qcount"}, 32'(q_count), 32'(exp_q.size()));
    check({tag, "_dir_stable"}, 32'(dir), 32'(cur_dir));
  endtask

  task automatic tick(input string tag);
    update_clk = 1'b1;
    if (exp_q.size() != 0) cur_dir = exp_q.pop_front();
    @(negedge sys_clk);
    check({tag, "_dir"}, 32'(dir), 32'(cur_dir));
    check({tag, "_qcount"}, 32'(q_count), 32'(exp_q.size()));
    repeat (2) @(negedge sys_clk);
    update_clk = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge sys_clk);
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    do_reset();

    // Debounce: short glitch ignored, long hold gives one turn
    press("glitch", 4'b0001, 3);
    press("down", 4'b0100, 10);
    tick("tick_down");

    // Reversal and same-direction rejection
    do_reset();
    press("rev_left", 4'b1000, 10);
    press("same_right", 4'b0010, 10);

    // Two-turn queue, overflow drop, one pop per tick
    press("q_up", 4'b0001, 10);
    press("q_left", 4'b1000, 10);
    press("q_full_down", 4'b0100, 10);
    tick("tick1");
    tick("tick2");
    tick("tick_empty");

    // Simultaneous presses keep only the highest priority
    do_reset();
    press("simul", 4'b0101, 10);
    press("fill_left", 4'b1000, 10);
    // Push (down) lands in the same cycle as a tick at q_count=2
    set_btns(4'b0100);
    repeat (5) @(negedge sys_clk);
    update_clk = 1'b1;
    cur_dir = exp_q.pop_front();
    exp_q.push_back(2'd2);
    @(negedge sys_clk);
    check("pushpop_dir", 32'(dir), 32'(cur_dir));
    check("pushpop_qcount", 32'(q_count), 2);
    check("pushpop_drop", 32'(turn_drop), 0);
    update_clk = 1'b0;
    set_btns(4'b0);
    repeat (8) @(negedge sys_clk);
    tick("order1");
    tick("order2");

    // Reset mid-operation with a held button
    do_reset();
    press("mid_up", 4'b0001, 10);
    press("mid_left", 4'b1000, 10);
    set_btns(4'b0100);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_q.delete();
    cur_dir = 2'b01;
    check("midrst_dir", 32'(dir), 32'(2'b01));
    check("midrst_qcount", 32'(q_count), 0);
    repeat (4) @(negedge sys_clk);
    check("midrst_no_early", 32'(q_count), 0);
    repeat (2) @(negedge sys_clk);
    exp_q.push_back(2'd2);
    check("midrst_press", 32'(q_count), 1);
    set_btns(4'b0);
    repeat (8) @(negedge sys_clk);
    tick("midrst_tick");

    // Random presses and ticks against the model
    for (int i = 0; i < 12; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      press("rand", m, 10);
      if ($urandom_range(0, 2) == 0) tick("rand_tick");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
